lsu_subword_rmw: RTL and testbench
==================================

Name: lsu_subword_rmw

Overview:
- Load/store alignment unit between the EX_MEM pipeline register and the byte-addressed, little-endian data memory.
- The memory always reads and writes 4 bytes starting at the address it is given, so this block:
  - word-aligns every access;
  - extracts and extends LB/LH/LBU/LHU results;
  - implements SB/SH as a 2-cycle read-modify-write that stalls the pipeline;
  - flags misaligned or out-of-range accesses.
- Load results feed MEM_WB.

Parameters:
- MEM_BYTES, 32, data memory size in bytes; must be a multiple of 4.
- ADDR_W, 32, address width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous active-high reset.
- addr_i  input  ADDR_W  effective address from EX_MEM.
- wdata_i  input  32  store data (rs2) from EX_MEM.
- funct3_i  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MemRead_i  input  1  load request.
- MemWrite_i  input  1  store request.
- mem_rdata_i  input  32  word read from memory at mem_addr_o (combinational).
- mem_addr_o  output  ADDR_W  word-aligned address to memory (addr & ~3).
- mem_wdata_o  output  32  word to write.
- mem_read_o  output  1  memory read enable.
- mem_write_o  output  1  memory write enable (memory writes on rising edge).
- load_data_o  output  32  extended load result to MEM_WB; 0 when no valid load.
- stall_o  output  1  hold PC, IF_ID, ID_EX, EX_MEM this cycle.
- fault_o  output  1  registered one-cycle pulse: misaligned or out-of-range access.
- fault_addr_o  output  ADDR_W  address of the most recent fault; held until the next fault or reset.

Behaviour:
- Definitions:
  - off = addr_i[1:0]; aligned = addr_i & ~3.
  - bad = (H/HU and off[0]) or (W and off != 0) or (addr_i > MEM_BYTES-4) or funct3 in {011, 11x}.
  - req = MemRead_i | MemWrite_i. If both are set, the store wins.
- FSM states: IDLE, MERGE. Reset value: IDLE.
- Reset: all registered outputs and registers clear (fault_o=0, fault_addr_o=0, merge_q=0).
  - While RESET=1, mem_write_o=0 and stall_o=0 combinationally, regardless of state.
- IDLE, load, not bad:
  - mem_read_o=1, mem_addr_o=aligned.
  - load_data_o is combinational (0-cycle latency). With byte = mem_rdata_i[8*off+:8] and half = mem_rdata_i[16*off[1]+:16]:
    - LB: sign-extend byte.
    - LBU: zero-extend byte.
    - LH: sign-extend half.
    - LHU: zero-extend half.
    - LW: the whole word.
  - No stall; stay IDLE.
- IDLE, SW, not bad: mem_write_o=1, mem_wdata_o=wdata_i, mem_addr_o=aligned, no stall; stay IDLE.
- IDLE, SB/SH, not bad:
  - mem_read_o=1, stall_o=1, mem_write_o=0.
  - merge_q <= mem_rdata_i with the byte (wdata_i[7:0]) or half (wdata_i[15:0]) lane at off replaced.
  - addr_q <= aligned; go to MERGE.
- MERGE:
  - mem_write_o=1, mem_addr_o=addr_q, mem_wdata_o=merge_q, stall_o=0, mem_read_o=0.
  - Next state is IDLE unconditionally.
  - The EX_MEM contents are unchanged (stalled), so the next IDLE cycle sees the new instruction only after the pipeline advances on this edge.
- Any req with bad:
  - No memory read or write, load_data_o=0, no stall.
  - Next edge: fault_o=1 for exactly one cycle, fault_addr_o<=addr_i.
- No req: all enables 0, load_data_o=0, stall_o=0.
- RESET asserted in MERGE: the pending write is dropped (no memory update) and the FSM returns to IDLE.
- Back-to-back SB to the same word: the second RMW reads the value already committed by the first MERGE write.
- Idle outputs: mem_wdata_o=0, mem_addr_o=aligned.
- Stall is asserted only in IDLE; SB/SH cost exactly 2 cycles, everything else 1.

Test Plan:
- Loads of word 0x80FF7F01 at address 0:
  - LB @1 -> 0x0000007F;
  - LB @2 -> 0xFFFFFFFF;
  - LBU @3 -> 0x00000080;
  - LH @2 -> 0xFFFF80FF;
  - LHU @0 -> 0x00007F01;
  - all with stall_o=0.
- SW 0xDEADBEEF @8 -> one cycle, mem_write_o=1, mem_addr_o=8; LW @8 next -> 0xDEADBEEF.
- Word @4 = 0x11223344, SB wdata 0xAA @6:
  - cycle 1: stall_o=1, mem_write_o=0;
  - cycle 2: mem_write_o=1, mem_wdata_o=0x11AA3344;
  - then LW @4 -> 0x11AA3344.
- SH 0xBEEF @4, then immediately SB 0x55 @7 on the same word -> final word 0x55??BEEF with byte 2 preserved; each store stalls exactly 1 cycle.
- Misaligned and out-of-range accesses:
  - LW @2 -> no enables, load_data_o=0, fault_o=1 next cycle only, fault_addr_o=2;
  - SH @5 -> same, fault_addr_o=5, memory unchanged;
  - LW @29 with MEM_BYTES=32 -> fault.
- RESET=1 during MERGE of SB @0 -> mem_write_o=0 that cycle, memory word 0 unchanged, state IDLE, fault_o=0, fault_addr_o=0.

Source files
------------

// File: rtl/lsu_subword_rmw_if.sv
// Bus between the EX_MEM stage / data memory and the load-store alignment unit.
// The slave side is the alignment unit; the master side is the pipeline and memory.
interface lsu_subword_rmw_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [2:0]        funct3_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [31:0]       mem_rdata_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [31:0]       load_data_o;
  logic              stall_o;
  logic              fault_o;
  logic [ADDR_W-1:0] fault_addr_o;

  modport slave (
    input  addr_i, wdata_i, funct3_i, MemRead_i, MemWrite_i, mem_rdata_i,
    output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o, load_data_o,
           stall_o, fault_o, fault_addr_o
  );

  modport master (
    output addr_i, wdata_i, funct3_i, MemRead_i, MemWrite_i, mem_rdata_i,
    input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o, load_data_o,
           stall_o, fault_o, fault_addr_o
  );
endinterface

// File: rtl/lsu_subword_rmw.sv
// Word-aligning load/store unit: extends sub-word loads, turns SB/SH into a
// stalling 2-cycle read-modify-write, and flags misaligned/out-of-range accesses.
module lsu_subword_rmw #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  lsu_subword_rmw_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  typedef enum logic {IDLE, MERGE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       merge_q, merge_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  logic [1:0]        off;
  logic [ADDR_W-1:0] aligned;
  logic              req, size_b, size_h, size_w, bad;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       merged, load_ext;

  always_comb begin
    off      = bus.addr_i[1:0];
    aligned  = bus.addr_i & ~ADDR_W'(3);
    req      = bus.MemRead_i | bus.MemWrite_i;
    size_b   = (bus.funct3_i[1:0] == 2'b00);
    size_h   = (bus.funct3_i[1:0] == 2'b01);
    size_w   = (bus.funct3_i[1:0] == 2'b10);
    bad      = (size_h & off[0]) | (size_w & (off != 2'b00)) | (bus.addr_i > LAST_WORD)
             | (bus.funct3_i == 3'b011) | (bus.funct3_i[2:1] == 2'b11);
    byte_sel = bus.mem_rdata_i[{off, 3'b000} +: 8];
    half_sel = bus.mem_rdata_i[{off[1], 4'b0000} +: 16];
    // Store lane replaced inside the word just read.
    merged   = bus.mem_rdata_i;
    if (size_b) merged[{off, 3'b000} +: 8]     = bus.wdata_i[7:0];
    else        merged[{off[1], 4'b0000} +: 16] = bus.wdata_i[15:0];
    case (bus.funct3_i)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      3'b010:  load_ext = bus.mem_rdata_i;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    merge_d         = merge_q;
    addr_d          = addr_q;
    fault_d         = 1'b0;
    fault_addr_d    = fault_addr_q;
    bus.mem_addr_o  = aligned;
    bus.mem_wdata_o = '0;
    bus.mem_read_o  = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.load_data_o = '0;
    bus.stall_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && bad) begin
          fault_d      = 1'b1;
          fault_addr_d = bus.addr_i;
        end else if (bus.MemWrite_i) begin
          if (size_w) begin
            bus.mem_write_o = 1'b1;
            bus.mem_wdata_o = bus.wdata_i;
          end else begin
            bus.mem_read_o = 1'b1;
            bus.stall_o    = 1'b1;
            merge_d        = merged;
            addr_d         = aligned;
            state_d        = MERGE;
          end
        end else if (bus.MemRead_i) begin
          bus.mem_read_o  = 1'b1;
          bus.load_data_o = load_ext;
        end
      end
      MERGE: begin
        bus.mem_write_o = 1'b1;
        bus.mem_addr_o  = addr_q;
        bus.mem_wdata_o = merge_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset landing on MERGE must not commit the half-built word.
    if (RESET) begin
      bus.mem_write_o = 1'b0;
      bus.stall_o     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      addr_q       <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      addr_q       <= addr_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.fault_o      = fault_q;
  assign bus.fault_addr_o = fault_addr_q;
endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Bench for lsu_subword_rmw: byte-array reference memory predicts every cycle's
// outputs; directed literals pin the model, then randomized accesses follow.
module tb_lsu_subword_rmw;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  lsu_subword_rmw_if #(.ADDR_W(32)) bus();
  lsu_subword_rmw #(.MEM_BYTES(32), .ADDR_W(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  // Environment memory: 8 words, combinational read, write on rising edge.
  logic [31:0] dmem [8];
  assign bus.mem_rdata_i = dmem[bus.mem_addr_o[4:2]];
  always @(posedge CLK) if (bus.mem_write_o) dmem[bus.mem_addr_o[4:2]] <= bus.mem_wdata_o;

  // Reference model state.
  logic [7:0]  refb [32];
  logic        pend_fault;
  logic [31:0] ref_fa;

  // Per-cycle expectations.
  logic        exp_valid = 1'b0;
  logic        exp_rd, exp_wr, exp_stall, exp_fault;
  logic [31:0] exp_addr, exp_wdata, exp_load, exp_fa;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_valid) begin
      chk("mem_read",   {31'd0, bus.mem_read_o},  {31'd0, exp_rd});
      chk("mem_write",  {31'd0, bus.mem_write_o}, {31'd0, exp_wr});
      chk("stall",      {31'd0, bus.stall_o},     {31'd0, exp_stall});
      chk("mem_addr",   bus.mem_addr_o,           exp_addr);
      chk("mem_wdata",  bus.mem_wdata_o,          exp_wdata);
      chk("load_data",  bus.load_data_o,          exp_load);
      chk("fault",      {31'd0, bus.fault_o},     {31'd0, exp_fault});
      chk("fault_addr", bus.fault_addr_o,         exp_fa);
    end
  end

  function automatic logic [31:0] ref_word(input int al);
    return {refb[al+3], refb[al+2], refb[al+1], refb[al]};
  endfunction

  // One clock cycle: apply inputs and expectations, cross the edge, advance model.
  task automatic drive(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, wd,
                       input logic e_rd, e_wr, e_stall, input logic [31:0] e_addr, e_wdata,
                       e_load, input logic e_bad, rst);
    RESET = rst; bus.MemRead_i = rd; bus.MemWrite_i = wr; bus.funct3_i = f3;
    bus.addr_i = a; bus.wdata_i = wd;
    exp_rd = e_rd; exp_wr = e_wr; exp_stall = e_stall; exp_addr = e_addr;
    exp_wdata = e_wdata; exp_load = e_load; exp_fault = pend_fault; exp_fa = ref_fa;
    exp_valid = 1'b1;
    @(posedge CLK);
    if (rst) begin
      pend_fault = 1'b0; ref_fa = '0;
    end else begin
      pend_fault = e_bad;
      if (e_bad) ref_fa = a;
    end
    #1;
  endtask

  // One pipeline instruction; res is the loaded value or the word committed.
  task automatic op(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, wd,
                    output logic [31:0] res);
    int nb, ai;
    logic bad;
    logic [31:0] al, v;
    al  = a & ~32'd3;
    nb  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((a % nb) != 0) || (a > 28);
    res = '0;
    ai  = int'(a);
    if (!rd && !wr)
      drive(rd, wr, f3, a, wd, 0, 0, 0, al, 0, 0, 0, 0);
    else if (bad)
      drive(rd, wr, f3, a, wd, 0, 0, 0, al, 0, 0, 1, 0);
    else if (wr) begin
      if (nb == 4) begin
        drive(rd, wr, f3, a, wd, 0, 1, 0, al, wd, 0, 0, 0);
        for (int k = 0; k < 4; k++) refb[ai+k] = wd[8*k +: 8];
        res = wd;
      end else begin
        drive(rd, wr, f3, a, wd, 1, 0, 1, al, 0, 0, 0, 0);
        for (int k = 0; k < nb; k++) refb[ai+k] = wd[8*k +: 8];
        res = ref_word(int'(al));
        drive(rd, wr, f3, a, wd, 0, 1, 0, al, res, 0, 0, 0);
      end
    end else begin
      if (nb == 1)      v = {24'd0, refb[ai]};
      else if (nb == 2) v = {16'd0, refb[ai+1], refb[ai]};
      else              v = ref_word(ai);
      if (!f3[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      drive(rd, wr, f3, a, wd, 1, 0, 0, al, 0, v, 0, 0);
      res = v;
    end
  endtask

  initial begin
    logic [31:0] r, mw;
    logic [2:0] f3;
    logic rd, wr;
    for (int i = 0; i < 8; i++) dmem[i] = '0;
    for (int i = 0; i < 32; i++) refb[i] = '0;
    pend_fault = 1'b0; ref_fa = '0;
    RESET = 1'b1; bus.MemRead_i = 0; bus.MemWrite_i = 0; bus.funct3_i = 0;
    bus.addr_i = 0; bus.wdata_i = 0;
    repeat (2) @(posedge CLK);
    #1;
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Preload and sub-word loads.
    op(0, 1, 3'b010, 0, 32'h80FF7F01, r);
    op(0, 1, 3'b010, 4, 32'h11223344, r);
    op(1, 0, 3'b000, 1, 0, r); chk("lit_LB1",  r, 32'h0000007F);
    op(1, 0, 3'b000, 2, 0, r); chk("lit_LB2",  r, 32'hFFFFFFFF);
    op(1, 0, 3'b100, 3, 0, r); chk("lit_LBU3", r, 32'h00000080);
    op(1, 0, 3'b001, 2, 0, r); chk("lit_LH2",  r, 32'hFFFF80FF);
    op(1, 0, 3'b101, 0, 0, r); chk("lit_LHU0", r, 32'h00007F01);
    // SW then LW.
    op(0, 1, 3'b010, 8, 32'hDEADBEEF, r);
    op(1, 0, 3'b010, 8, 0, r); chk("lit_LW8", r, 32'hDEADBEEF);
    // Sub-word RMW, including back-to-back on one word.
    op(0, 1, 3'b000, 6, 32'h000000AA, r); chk("lit_SB6", r, 32'h11AA3344);
    op(1, 0, 3'b010, 4, 0, r);            chk("lit_LW4a", r, 32'h11AA3344);
    op(0, 1, 3'b001, 4, 32'h0000BEEF, r); chk("lit_SH4", r, 32'h11AABEEF);
    op(0, 1, 3'b000, 7, 32'h00000055, r); chk("lit_SB7", r, 32'h55AABEEF);
    op(1, 0, 3'b010, 4, 0, r);            chk("lit_LW4b", r, 32'h55AABEEF);
    // Faults.
    op(1, 0, 3'b010, 2, 0, r);
    op(0, 0, 3'b000, 0, 0, r);
    op(0, 1, 3'b001, 5, 32'h1234, r);
    op(0, 0, 3'b000, 0, 0, r);
    op(1, 0, 3'b010, 29, 0, r);
    op(0, 0, 3'b000, 0, 0, r);
    chk("lit_fa29", ref_fa, 32'd29);
    op(1, 0, 3'b010, 4, 0, r);            chk("lit_LW4c", r, 32'h55AABEEF);

    // Reset during MERGE of SB @0: write dropped, fault address cleared.
    drive(0, 1, 3'b000, 0, 32'h99, 1, 0, 1, 0, 0, 0, 0, 0);
    mw = {refb[3], refb[2], refb[1], 8'h99};
    drive(0, 1, 3'b000, 0, 32'h99, 0, 0, 0, 0, mw, 0, 0, 1);
    op(1, 0, 3'b010, 0, 0, r);            chk("lit_LW0_rst", r, 32'h80FF7F01);

    // Randomized traffic, including store-wins when both requests are set.
    for (int n = 0; n < 400; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (wr) begin
        case ($urandom_range(0, 5))
          0, 1:    f3 = 3'b000;
          2, 3:    f3 = 3'b001;
          4:       f3 = 3'b010;
          default: f3 = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b110;
        endcase
      end else begin
        case ($urandom_range(0, 6))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          4: f3 = 3'b101; 5: f3 = 3'b010;
          default: f3 = 3'b111;
        endcase
      end
      op(rd, wr, f3, 32'($urandom_range(0, 35)), $urandom, r);
    end
    op(0, 0, 3'b000, 0, 0, r);
    for (int i = 0; i < 8; i++) chk("final_mem", dmem[i], ref_word(4 * i));

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
